bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single memory/register bus between up to N requesters, such as the CPU control sequencer, the front-panel deposit/examine logic and I/O. It grants one requester at a time, holds the grant until release, inserts a bus-turnaround gap between owners, and can preempt an owner that has held the bus too long. It sits between the requester control FSMs and the bus drivers. Its gnt outputs directly enable the drivers' output stages.

---
 rtl/bus_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-hot registered grant held until release, a fixed
// turnaround gap between owners, and optional preemption of long-held grants.
module bus_arbiter #(
  parameter int N           = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                 clk,
  input  logic                 nclr,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 preempt
);

  localparam int              OW        = $clog2(N);
  localparam logic [7:0]      HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [2:0]      TURN_LOAD = 3'(TURN_CYCLES);
  localparam logic [OW-1:0]   OWNER_RST = OW'(N - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;
  logic [7:0]    hold_q, hold_d;
  logic [2:0]    turn_q, turn_d;

  int            scan_sum;
  logic [OW-1:0] scan_idx;
  logic [OW-1:0] win_idx;
  logic          win_vld;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  owner_oh;

  // Winner: first set req bit scanning upward from owner+1, wrapping modulo N.
  always_comb begin
    scan_sum = 0;
    scan_idx = '0;
    win_vld  = 1'b0;
    win_idx  = owner_q;
    for (int i = 1; i <= N; i++) begin
      scan_sum = (int'(owner_q) + i) % N;
      scan_idx = OW'(scan_sum);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
    win_oh            = '0;
    win_oh[win_idx]   = 1'b1;
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    turn_d    = turn_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          owner_d = win_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = TURN;
          gnt_d   = '0;
          turn_d  = TURN_LOAD;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|(req & ~owner_oh))) begin
          state_d   = TURN;
          gnt_d     = '0;
          preempt_d = 1'b1;
          turn_d    = TURN_LOAD;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        turn_d = turn_q - 3'd1;
        // Requests are only looked at on the final turnaround edge.
        if (turn_q == 3'd1) begin
          if (win_vld) begin
            state_d = GRANT;
            gnt_d   = win_oh;
            owner_d = win_idx;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= OWNER_RST;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three parameterisations share req/nclr and are compared
// every cycle against a grant/gap/hold reference model, plus directed scenarios.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       nclr;
  logic [3:0] req;
  logic [3:0] gnt     [3];
  logic [1:0] owner   [3];
  logic       busy    [3];
  logic       preempt [3];

  int checks = 0;
  int errors = 0;

  // Reference model state: last grantee, current grantee (-1 none), cycles held, gap left.
  int m_owner [3];
  int m_cur   [3];
  int m_held  [3];
  int m_gap   [3];
  bit m_pre   [3];

  always #5 clk = ~clk;

  bus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .nclr(nclr), .req(req), .gnt(gnt[0]), .owner(owner[0]),
    .busy(busy[0]), .preempt(preempt[0]));
  bus_arbiter #(.N(4), .TURN_CYCLES(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .nclr(nclr), .req(req), .gnt(gnt[1]), .owner(owner[1]),
    .busy(busy[1]), .preempt(preempt[1]));
  bus_arbiter #(.N(4), .TURN_CYCLES(2), .MAX_HOLD(0)) dut_c (
    .clk(clk), .nclr(nclr), .req(req), .gnt(gnt[2]), .owner(owner[2]),
    .busy(busy[2]), .preempt(preempt[2]));

  function automatic int tc(int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int mh(int d);
    return (d == 2) ? 0 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = 3;
      m_cur[d]   = -1;
      m_held[d]  = 0;
      m_gap[d]   = 0;
      m_pre[d]   = 1'b0;
    end
  endtask

  task automatic model_pick(int d);
    bit done;
    int c;
    done = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c = (m_owner[d] + k) % 4;
      if (!done && req[c]) begin
        done       = 1'b1;
        m_cur[d]   = c;
        m_owner[d] = c;
        m_held[d]  = 0;
      end
    end
  endtask

  task automatic model_step(int d);
    logic [3:0] oh;
    m_pre[d] = 1'b0;
    if (m_cur[d] >= 0) begin
      oh = 4'b0001 << m_cur[d];
      if (!req[m_cur[d]]) begin
        m_cur[d] = -1;
        m_gap[d] = tc(d);
      end else if (mh(d) > 0 && m_held[d] == mh(d) && (req & ~oh) != 4'b0000) begin
        m_cur[d] = -1;
        m_gap[d] = tc(d);
        m_pre[d] = 1'b1;
      end else if (m_held[d] < mh(d)) begin
        m_held[d] = m_held[d] + 1;
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d] = m_gap[d] - 1;
      if (m_gap[d] == 0) model_pick(d);
    end else begin
      model_pick(d);
    end
  endtask

  function automatic logic [7:0] exp_vec(int d);
    logic [3:0] g;
    logic [1:0] o;
    g = '0;
    if (m_cur[d] >= 0) g[m_cur[d]] = 1'b1;
    o = m_owner[d][1:0];
    return {g, o, |g, m_pre[d]};
  endfunction

  function automatic logic [7:0] dut_vec(int d);
    return {gnt[d], owner[d], busy[d], preempt[d]};
  endfunction

  task automatic step_clk();
    @(posedge clk);
    if (nclr) begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
    #1;
  endtask

  task automatic do_reset();
    req  = '0;
    nclr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    nclr = 1'b1;
  endtask

  task automatic test_reset();
    nclr = 1'b1;
    req  = '0;
    #2;
    nclr = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== 8'b0000_11_0_0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %b want %b", d, dut_vec(d), 8'b0000_11_0_0);
      end
    end
    step_clk();
    nclr = 1'b1;
    step_clk();
    step_clk();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== 8'b0000_11_0_0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got %b want %b", d, dut_vec(d), 8'b0000_11_0_0);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    step_clk();
    checks++;
    if (dut_vec(0) !== 8'b0001_00_1_0) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", dut_vec(0), 8'b0001_00_1_0);
    end
    req = 4'b0000;
    step_clk();
    checks++;
    if (dut_vec(0) !== 8'b0000_00_0_0) begin
      errors++;
      $display("FAIL single_release: got %b want %b", dut_vec(0), 8'b0000_00_0_0);
    end
    for (int c = 0; c < 5; c++) begin
      step_clk();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL single_model dut%0d: got %b want %b", d, dut_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int pend;
    logic [3:0] want;
    do_reset();
    req  = 4'b1111;
    pend = -1;
    for (int i = 0; i < 19; i++) begin
      step_clk();
      want = (i % 4 == 3) ? 4'b0000 : (4'b0001 << ((i / 4) % 4));
      checks++;
      if (gnt[0] !== want) begin
        errors++;
        $display("FAIL rr_order cycle %0d: got %b want %b", i, gnt[0], want);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL rr_model dut%0d: got %b want %b", d, dut_vec(d), exp_vec(d));
        end
      end
      if (pend >= 0) begin
        req[pend] = 1'b1;
        pend      = -1;
      end
      if (m_cur[0] >= 0 && m_held[0] == 2) begin
        pend         = m_cur[0];
        req[m_cur[0]] = 1'b0;
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] w_g [10];
    logic [1:0] w_o [10];
    logic       w_p [10];
    w_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1};
    w_o = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    w_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      checks++;
      if ({gnt[0], owner[0], preempt[0]} !== {w_g[i], w_o[i], w_p[i]}) begin
        errors++;
        $display("FAIL preempt_seq cycle %0d: got %b/%0d/%b want %b/%0d/%b",
                 i, gnt[0], owner[0], preempt[0], w_g[i], w_o[i], w_p[i]);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL preempt_model dut%0d: got %b want %b", d, dut_vec(d), exp_vec(d));
        end
      end
      if (i == 1) req = 4'b0101;
      if (i == 7) req = 4'b0001;
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (gnt[d] !== 4'b0010 || preempt[d] !== 1'b0) begin
          errors++;
          $display("FAIL nopre_hold dut%0d cycle %0d: got %b/%b want 0010/0", d, i, gnt[d], preempt[d]);
        end
      end
    end
    req = 4'b0000;
    step_clk();
  endtask

  task automatic test_turn_sampling();
    logic [3:0] w_g [4];
    w_g = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
    do_reset();
    req = 4'b0001;
    step_clk();
    step_clk();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      checks++;
      if (gnt[1] !== w_g[i] || (i == 3 && owner[1] !== 2'd3)) begin
        errors++;
        $display("FAIL turn_sample cycle %0d: got %b/%0d want %b", i, gnt[1], owner[1], w_g[i]);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL turn_model dut%0d: got %b want %b", d, dut_vec(d), exp_vec(d));
        end
      end
      if (i == 0) req = 4'b0010;
      if (i == 1) req = 4'b1000;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    step_clk();
    checks++;
    if (dut_vec(0) !== 8'b0100_10_1_0) begin
      errors++;
      $display("FAIL areset_pre: got %b want %b", dut_vec(0), 8'b0100_10_1_0);
    end
    step_clk();
    #2;
    nclr = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== 8'b0000_11_0_0) begin
        errors++;
        $display("FAIL areset_drop dut%0d: got %b want %b", d, dut_vec(d), 8'b0000_11_0_0);
      end
    end
    req = 4'b0110;
    #1;
    nclr = 1'b1;
    step_clk();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dut_vec(d) !== 8'b0010_01_1_0) begin
        errors++;
        $display("FAIL areset_first dut%0d: got %b want %b", d, dut_vec(d), 8'b0010_01_1_0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199) == 0) begin
        nclr = 1'b0;
        model_reset();
        #1;
        nclr = 1'b1;
      end
      step_clk();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random_model dut%0d cycle %0d: got %b want %b", d, i, dut_vec(d), exp_vec(d));
        end
        checks++;
        if (!$onehot0(gnt[d]) || busy[d] !== (|gnt[d])) begin
          errors++;
          $display("FAIL random_invariant dut%0d cycle %0d: gnt %b busy %b", d, i, gnt[d], busy[d]);
        end
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) req[b] = ~req[b];
      end
    end
  endtask

  initial begin
    nclr = 1'b1;
    req  = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_no_preempt();
    test_turn_sampling();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
